sprite_compositor: RTL
======================

// Module: sprite_compositor
// PURPOSE
//  Downstream of the sprite renderers: merges NLAYERS sprite pixel streams (pix + drawing) into one 12-bit RGB pixel.
//  Uses fixed priority (layer 0 on top), falling back to a background colour index.
//  Also accumulates per-frame layer-pair overlap (collision) flags and reports them to game logic once per frame
//  over a valid/ack handshake.
// PARAMETERS
//  NLAYERS    4   number of sprite layers (2..8)
//  PIX_BITS   4   colour-index bits per layer pixel (index 0 = transparent)
//  RGB_BITS   12  output colour width (4:4:4)
// PORTS
//  clk_pix      in   1                  pixel clock
//  rst_n        in   1                  async active-low reset
//  frame        in   1                  1-cycle pulse, start of frame
//  de           in   1                  display enable (visible pixel)
//  layer_pix    in   NLAYERS*PIX_BITS   layer k index at [k*PIX_BITS +: PIX_BITS]
//  layer_draw   in   NLAYERS            layer k drawing a non-transparent pixel
//  bg_idx       in   PIX_BITS           background colour index
//  rgb          out  RGB_BITS           composited colour, 0 when de_out=0
//  de_out       out  1                  de delayed to align with rgb
//  coll_valid   out  1                  collision report pending
//  coll_matrix  out  NLAYERS*NLAYERS    bit i*NLAYERS+j (i<j) = layers i,j overlapped last frame
//  coll_overrun out  1                  an unacked report was overwritten
//  coll_ack     in   1                  consumer accepts report
//  pal_we       in   1                  palette write strobe (PALETTE_EN only)
//  pal_addr     in   PIX_BITS           palette write address (PALETTE_EN only)
//  pal_data     in   RGB_BITS           palette write data (PALETTE_EN only)
// BEHAVIOUR
//  Reset (async on rst_n low): rgb=0, de_out=0, coll_valid=0, coll_matrix=0, coll_overrun=0, accumulator=0,
//   both pipeline stages cleared, state=ACCUM.
//  Pipeline: fixed 2-cycle latency, de/pix sampled at cycle t -> rgb/de_out at t+2; no stalls.
//  S1 (register): idx = layer_pix of lowest k with layer_draw[k]=1 AND layer_pix[k]!=0; else bg_idx. Registers de.
//  S2 (register): rgb = de_s1 ? colour(idx) : 0; de_out = de_s1.
//  Overlap: each cycle with de=1, for every i<j with both layers drawing non-zero, set acc[i*NLAYERS+j].
//   Bits with i>=j are never set.
//  Report FSM, states ACCUM / HOLD:
//   ACCUM: on frame -> coll_matrix<=acc, coll_valid<=1, acc cleared, go HOLD.
//   HOLD: coll_ack=1 -> coll_valid<=0, coll_overrun<=0, go ACCUM.
//         frame while unacked -> coll_matrix<=acc, coll_overrun<=1, acc cleared, stay HOLD.
//   Simultaneous frame+ack in HOLD: frame wins -> new report loaded, coll_valid stays 1, coll_overrun<=0.
//   coll_ack while coll_valid=0 is ignored.
//  Overlaps sampled in the frame-pulse cycle belong to the NEW frame's accumulator.
//  Accumulation continues in both states; acc is sticky until the next frame pulse.
//  Reset mid-frame discards acc and any pending report; no report is produced for the partial frame.
// CONFIGURATION
//  `define PALETTE_EN: 2**PIX_BITS x RGB_BITS register palette, colour(idx)=pal[idx].
//   Write on clk_pix when pal_we=1, visible at S2 in the following cycle.
//   Reset contents: pal[k]={k,k,k} (grey ramp).
//   A write to the entry being read in the same cycle returns the OLD value.
//  Not defined: pal_* ports absent; colour(idx)={idx,idx,idx} (same as palette reset state).
// TESTING
//  1 Reset: rst_n=0 mid-stream -> rgb=0, de_out=0, coll_valid=0 immediately (async); after release first rgb at t+2.
//  2 Priority: de=1, layer0 idx5 draw, layer2 idx9 draw -> rgb=12'h555 at t+2. Drop layer0 -> 12'h999.
//    None drawing, bg_idx=1 -> 12'h111.
//  3 Transparent: layer0 draw=1 pix=0, layer1 pix=3 -> rgb=12'h333. de=0 -> rgb=0 regardless of layers.
//  4 Collision: layers 1&3 overlap one pixel, then frame -> coll_valid=1, coll_matrix bit 7 only.
//    ack -> coll_valid=0 next cycle.
//  5 Overrun: two frames without ack, second frame overlap 0&1 -> coll_matrix=bit 1 only, coll_overrun=1.
//    frame+ack same cycle -> coll_valid=1, coll_overrun=0.
//  6 PALETTE_EN: write pal[5]=12'hF00, then layer0 idx5 -> rgb=12'hF00.
//    Without macro, same stimulus -> 12'h555.

Source files
------------

// File: rtl/sprite_compositor.sv
// Sprite layer compositor: fixed-priority merge of NLAYERS index streams into RGB, plus per-frame
// layer-pair collision reporting over a valid/ack handshake. Optional PALETTE_EN adds a writable palette.
module sprite_compositor #(
  parameter int unsigned NLAYERS  = 4,
  parameter int unsigned PIX_BITS = 4,
  parameter int unsigned RGB_BITS = 12
) (
  input  logic                          clk_pix,
  input  logic                          rst_n,
  input  logic                          frame,
  input  logic                          de,
  input  logic [NLAYERS*PIX_BITS-1:0]   layer_pix,
  input  logic [NLAYERS-1:0]            layer_draw,
  input  logic [PIX_BITS-1:0]           bg_idx,
`ifdef PALETTE_EN
  input  logic                          pal_we,
  input  logic [PIX_BITS-1:0]           pal_addr,
  input  logic [RGB_BITS-1:0]           pal_data,
`endif
  output logic [RGB_BITS-1:0]           rgb,
  output logic                          de_out,
  output logic                          coll_valid,
  output logic [NLAYERS*NLAYERS-1:0]    coll_matrix,
  output logic                          coll_overrun,
  input  logic                          coll_ack
);

  localparam int unsigned NPAIR = NLAYERS * NLAYERS;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  function automatic logic [RGB_BITS-1:0] grey(input logic [PIX_BITS-1:0] i);
    return RGB_BITS'({i, i, i});
  endfunction

  logic [NLAYERS-1:0]  active_c;
  logic [PIX_BITS-1:0] idx_d, idx_s1_q;
  logic                de_s1_q;
  logic [RGB_BITS-1:0] colour_c;
  logic [RGB_BITS-1:0] rgb_q;
  logic                de_out_q;
  logic [NPAIR-1:0]    hit_c;

  logic [0:0]       state_q, state_d;
  logic [NPAIR-1:0] acc_q, acc_d;
  logic [NPAIR-1:0] matrix_q, matrix_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // A layer counts only when drawing a non-transparent index
  always_comb begin
    active_c = '0;
    for (int k = 0; k < NLAYERS; k++) begin
      active_c[k] = layer_draw[k] && (layer_pix[k*PIX_BITS +: PIX_BITS] != '0);
    end
  end

  // Lowest active layer wins; scan from the top so layer 0 is applied last
  always_comb begin
    idx_d = bg_idx;
    for (int k = NLAYERS - 1; k >= 0; k--) begin
      if (active_c[k]) idx_d = layer_pix[k*PIX_BITS +: PIX_BITS];
    end
  end

  always_comb begin
    hit_c = '0;
    if (de) begin
      for (int i = 0; i < NLAYERS; i++) begin
        for (int j = i + 1; j < NLAYERS; j++) begin
          if (active_c[i] && active_c[j]) hit_c[i*NLAYERS + j] = 1'b1;
        end
      end
    end
  end

`ifdef PALETTE_EN
  logic [RGB_BITS-1:0] pal_q [2**PIX_BITS];

  // Reads sample the pre-write contents, so a same-cycle write returns the old entry
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2**PIX_BITS; k++) pal_q[k] <= grey(PIX_BITS'(k));
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  assign colour_c = pal_q[idx_s1_q];
`else
  assign colour_c = grey(idx_s1_q);
`endif

  // Two-stage pixel pipeline: S1 selects the index, S2 maps it to colour
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      idx_s1_q <= '0;
      de_s1_q  <= 1'b0;
      rgb_q    <= '0;
      de_out_q <= 1'b0;
    end else begin
      idx_s1_q <= idx_d;
      de_s1_q  <= de;
      rgb_q    <= de_s1_q ? colour_c : '0;
      de_out_q <= de_s1_q;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      matrix_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      matrix_q  <= matrix_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Report FSM; overlaps seen in the frame-pulse cycle seed the new accumulator
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q | hit_c;
    matrix_d  = matrix_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_ACCUM: begin
        if (frame) begin
          matrix_d  = acc_q;
          acc_d     = hit_c;
          valid_d   = 1'b1;
          overrun_d = 1'b0;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (frame) begin
          matrix_d  = acc_q;
          acc_d     = hit_c;
          overrun_d = !coll_ack;
        end else if (coll_ack) begin
          valid_d   = 1'b0;
          overrun_d = 1'b0;
          state_d   = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  assign rgb          = rgb_q;
  assign de_out       = de_out_q;
  assign coll_valid   = valid_q;
  assign coll_matrix  = matrix_q;
  assign coll_overrun = overrun_q;

endmodule
